// File: rtl/fpu16.sv
// rtl/fpu16.sv - binary16 FPU: combinational add/sub, 12-cycle shift-and-add multiply.
// Define FPU16_COMPARE_EN to build the LT/EQ/GT comparator on comps.
module fpu16 (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] fpuIn1,
   input  logic [15:0] fpuIn2,
   output logic [15:0] fpuOut,
   output logic        mulDone,
   output logic [3:0]  condCodes,
   output logic [4:0]  statusFlags,
   output logic [2:0]  comps
);

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [15:0] QNAN  = 16'h7E00;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic is_nan(input logic [15:0] v);
      return (&v[14:10]) & (|v[9:0]);
   endfunction

   function automatic logic is_snan(input logic [15:0] v);
      return is_nan(v) & ~v[9];
   endfunction

   function automatic logic is_inf(input logic [15:0] v);
      return (&v[14:10]) & ~(|v[9:0]);
   endfunction

   function automatic logic is_zero(input logic [15:0] v);
      return ~(|v[14:0]);
   endfunction

   function automatic logic [4:0] eff_exp(input logic [15:0] v);
      return (v[14:10] == 5'd0) ? 5'd1 : v[14:10];
   endfunction

   function automatic logic [10:0] sig11(input logic [15:0] v);
      return {|v[14:10], v[9:0]};
   endfunction

   // sig has its units bit at [24]; value = sig/2^24 * 2^(exp_in-15).
   // Returns {result[15:0], OF, UF, NX} after RNE rounding with gradual underflow.
   function automatic logic [18:0] round_pack(input logic sign,
                                              input logic signed [8:0] exp_in,
                                              input logic [25:0] sig);
      logic [4:0]        lead;
      logic signed [9:0] e_norm;
      logic signed [9:0] e_tgt;
      logic signed [9:0] sh;
      logic [25:0]       n;
      logic              sticky;
      logic              rnd;
      logic              inexact;
      logic [16:0]       mag;
      lead = '0;
      for (int i = 0; i < 26; i++) begin
         if (sig[i]) lead = 5'(i);
      end
      e_norm = 10'(exp_in) + $signed({5'b0, lead}) - 10'sd24;
      e_tgt  = (e_norm < 10'sd1) ? 10'sd1 : e_norm;
      sh     = e_tgt - 10'(exp_in);
      sticky = 1'b0;
      if (sh < 10'sd0) begin
         n = sig << (-sh);
      end else if (sh >= 10'sd26) begin
         n      = '0;
         sticky = |sig;
      end else begin
         n      = sig >> sh;
         sticky = |(sig & ~({26{1'b1}} << sh));
      end
      sticky  = sticky | (|n[12:0]) | n[25];
      inexact = n[13] | sticky;
      rnd     = n[13] & (sticky | n[14]);
      mag     = {(n[24] ? e_tgt[6:0] : 7'd0), n[23:14]} + {16'd0, rnd};
      if (sig == 26'd0)
         return {sign, 15'd0, 3'b000};
      else if (mag >= 17'h07C00)
         return {sign, 15'h7C00, 3'b101};
      else
         return {sign, mag[14:0], 1'b0, ~n[24] & inexact, inexact};
   endfunction

   // ---------------- combinational add / subtract ----------------
   logic [15:0] b_eff, x_op, y_op;
   logic        swap;
   logic [4:0]  ex, ey, dexp;
   logic [13:0] y_full, y_al, y_aligned;
   logic        y_sticky;
   logic [14:0] sum;
   logic [18:0] add_rp;
   logic [15:0] add_res;
   logic [4:0]  add_flags;

   always_comb begin
      b_eff = {fpuIn2[15] ^ (op == OP_SUB), fpuIn2[14:0]};
      swap  = b_eff[14:0] > fpuIn1[14:0];
      x_op  = swap ? b_eff : fpuIn1;
      y_op  = swap ? fpuIn1 : b_eff;
      ex    = eff_exp(x_op);
      ey    = eff_exp(y_op);
      dexp  = ex - ey;
      y_full = {sig11(y_op), 3'b000};
      if (dexp >= 5'd14) begin
         y_al     = '0;
         y_sticky = |y_full;
      end else begin
         y_al     = y_full >> dexp;
         y_sticky = |(y_full & ~(14'h3FFF << dexp));
      end
      // guard/round/sticky live in the three low bits
      y_aligned = {y_al[13:1], y_al[0] | y_sticky};
      if (x_op[15] == y_op[15])
         sum = {1'b0, sig11(x_op), 3'b000} + {1'b0, y_aligned};
      else
         sum = {1'b0, sig11(x_op), 3'b000} - {1'b0, y_aligned};
      add_rp    = round_pack(x_op[15], $signed({4'b0, ex}), {sum, 11'b0});
      add_res   = add_rp[18:3];
      add_flags = {2'b00, add_rp[2:0]};
      if (sum == 15'd0) begin
         add_res   = {x_op[15] & y_op[15], 15'd0};
         add_flags = 5'd0;
      end
      if (is_nan(fpuIn1) | is_nan(fpuIn2)) begin
         add_res   = QNAN;
         add_flags = {is_snan(fpuIn1) | is_snan(fpuIn2), 4'd0};
      end else if (is_inf(x_op) & is_inf(y_op) & (x_op[15] != y_op[15])) begin
         add_res   = QNAN;
         add_flags = 5'b10000;
      end else if (is_inf(x_op)) begin
         add_res   = {x_op[15], 15'h7C00};
         add_flags = 5'd0;
      end
   end

   // ---------------- sequential multiply ----------------
   state_t      state, state_nx;
   logic        launch;
   logic [15:0] a_reg, b_reg;
   logic [21:0] acc;
   logic [3:0]  cnt;
   logic [15:0] prod_reg;
   logic [4:0]  pflags_reg;
   logic [10:0] sig_b;
   logic [21:0] partial;
   logic signed [8:0] mexp;
   logic [18:0] mul_rp;
   logic [15:0] mul_res;
   logic [4:0]  mul_flags;
   logic        msign;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      case (state)
         IDLE: if (start && op == OP_MUL) begin
            state_nx = BUSY;
            launch   = 1'b1;
         end
         BUSY: if (cnt == 4'd11) state_nx = DONE;
         DONE: if (start && op == OP_MUL) begin
            state_nx = BUSY;
            launch   = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      sig_b   = sig11(b_reg);
      partial = {11'd0, sig11(a_reg)} << cnt;
      msign   = a_reg[15] ^ b_reg[15];
      mexp    = $signed({4'b0, eff_exp(a_reg)}) + $signed({4'b0, eff_exp(b_reg)}) - 9'sd15;
      mul_rp  = round_pack(msign, mexp, {acc, 4'b0000});
      mul_res   = mul_rp[18:3];
      mul_flags = {2'b00, mul_rp[2:0]};
      if (is_nan(a_reg) | is_nan(b_reg)) begin
         mul_res   = QNAN;
         mul_flags = {is_snan(a_reg) | is_snan(b_reg), 4'd0};
      end else if ((is_inf(a_reg) & is_zero(b_reg)) | (is_zero(a_reg) & is_inf(b_reg))) begin
         mul_res   = QNAN;
         mul_flags = 5'b10000;
      end else if (is_inf(a_reg) | is_inf(b_reg)) begin
         mul_res   = {msign, 15'h7C00};
         mul_flags = 5'd0;
      end else if (is_zero(a_reg) | is_zero(b_reg)) begin
         mul_res   = {msign, 15'd0};
         mul_flags = 5'd0;
      end
   end

   // cnt 0..10 accumulate one partial product each; cnt 11 is the round cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         a_reg      <= '0;
         b_reg      <= '0;
         acc        <= '0;
         cnt        <= '0;
         prod_reg   <= '0;
         pflags_reg <= '0;
      end else if (launch) begin
         a_reg <= fpuIn1;
         b_reg <= fpuIn2;
         acc   <= '0;
         cnt   <= '0;
      end else if (state == BUSY) begin
         cnt <= cnt + 4'd1;
         if (cnt == 4'd11) begin
            prod_reg   <= mul_res;
            pflags_reg <= mul_flags;
         end else if (sig_b[cnt]) begin
            acc <= acc + partial;
         end
      end
   end

   assign mulDone = (state == DONE);

   // ---------------- output select and condition codes ----------------
   always_comb begin
      fpuOut      = 16'd0;
      statusFlags = 5'd0;
      case (op)
         OP_ADD, OP_SUB: begin
            fpuOut      = add_res;
            statusFlags = add_flags;
         end
         OP_MUL: begin
            fpuOut      = prod_reg;
            statusFlags = pflags_reg;
         end
         default: ;
      endcase
      condCodes = {is_zero(fpuOut), fpuOut[15] & ~is_nan(fpuOut),
                   is_inf(fpuOut), is_nan(fpuOut)};
   end

`ifdef FPU16_COMPARE_EN
   always_comb begin
      comps = 3'b000;
      if (!(is_nan(fpuIn1) || is_nan(fpuIn2))) begin
         if ((is_zero(fpuIn1) && is_zero(fpuIn2)) || fpuIn1 == fpuIn2)
            comps = 3'b010;
         else if (fpuIn1[15] != fpuIn2[15])
            comps = fpuIn1[15] ? 3'b100 : 3'b001;
         else if ((fpuIn1[14:0] < fpuIn2[14:0]) ^ fpuIn1[15])
            comps = 3'b100;
         else
            comps = 3'b001;
      end
   end
`else
   assign comps = 3'b000;
`endif

endmodule

// File: tb/tb_fpu16.sv
// tb/tb_fpu16.sv - directed vector bench for fpu16.
module tb_fpu16;
   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [15:0] fpuIn1, fpuIn2;
   logic [15:0] fpuOut;
   logic        mulDone;
   logic [3:0]  condCodes;
   logic [4:0]  statusFlags;
   logic [2:0]  comps;

   fpu16 dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuOut(fpuOut), .mulDone(mulDone),
      .condCodes(condCodes), .statusFlags(statusFlags), .comps(comps)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a, b, res;
      logic [4:0]  flg;
      logic [3:0]  cc;
      logic [2:0]  cmp;
   } cvec_t;

   typedef struct {
      logic [15:0] a, b, res;
      logic [4:0]  flg;
      logic [3:0]  cc;
   } mvec_t;

   cvec_t cv[18];
   mvec_t mv[7];

   task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                          output int cycles, output logic early_done);
      @(negedge clock);
      op = 2'd2; fpuIn1 = a; fpuIn2 = b; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      early_done = mulDone;
      cycles = 0;
      while (!mulDone && cycles < 40) begin
         @(negedge clock);
         cycles++;
      end
   endtask

   initial begin
      int          cyc;
      logic        early;
      logic        seen_done;
      logic [2:0]  exp_cmp;

      //           op     a         b         res       flags     cc       cmp
      cv[0]  = '{2'd0, 16'h3C00, 16'h3C00, 16'h4000, 5'b00000, 4'b0000, 3'b010};
      cv[1]  = '{2'd1, 16'h3C00, 16'h3C00, 16'h0000, 5'b00000, 4'b1000, 3'b010};
      cv[2]  = '{2'd0, 16'h3C00, 16'h0001, 16'h3C00, 5'b00001, 4'b0000, 3'b001};
      cv[3]  = '{2'd0, 16'h7C00, 16'hFC00, 16'h7E00, 5'b10000, 4'b0001, 3'b001};
      cv[4]  = '{2'd0, 16'h0001, 16'h0001, 16'h0002, 5'b00000, 4'b0000, 3'b010};
      cv[5]  = '{2'd0, 16'h8000, 16'h8000, 16'h8000, 5'b00000, 4'b1100, 3'b010};
      cv[6]  = '{2'd0, 16'h7BFF, 16'h7BFF, 16'h7C00, 5'b00101, 4'b0010, 3'b010};
      cv[7]  = '{2'd0, 16'h7C00, 16'h7E00, 16'h7E00, 5'b00000, 4'b0001, 3'b000};
      cv[8]  = '{2'd0, 16'h7C01, 16'h3C00, 16'h7E00, 5'b10000, 4'b0001, 3'b000};
      cv[9]  = '{2'd1, 16'h3C00, 16'h4000, 16'hBC00, 5'b00000, 4'b0100, 3'b100};
      cv[10] = '{2'd0, 16'h3C00, 16'h3C01, 16'h4000, 5'b00001, 4'b0000, 3'b100};
      cv[11] = '{2'd0, 16'h3C00, 16'h3C03, 16'h4002, 5'b00001, 4'b0000, 3'b100};
      cv[12] = '{2'd0, 16'h0401, 16'h8400, 16'h0001, 5'b00000, 4'b0000, 3'b001};
      cv[13] = '{2'd0, 16'h03FF, 16'h0001, 16'h0400, 5'b00000, 4'b0000, 3'b001};
      cv[14] = '{2'd1, 16'hFC00, 16'hFC00, 16'h7E00, 5'b10000, 4'b0001, 3'b010};
      cv[15] = '{2'd0, 16'h0000, 16'h8000, 16'h0000, 5'b00000, 4'b1000, 3'b010};
      cv[16] = '{2'd3, 16'h1234, 16'h5678, 16'h0000, 5'b00000, 4'b1000, 3'b100};
      cv[17] = '{2'd1, 16'hC000, 16'h3C00, 16'hC200, 5'b00000, 4'b0100, 3'b100};

      mv[0] = '{16'h4000, 16'h4200, 16'h4600, 5'b00000, 4'b0000};
      mv[1] = '{16'h7BFF, 16'h4000, 16'h7C00, 5'b00101, 4'b0010};
      mv[2] = '{16'h0000, 16'h7C00, 16'h7E00, 5'b10000, 4'b0001};
      mv[3] = '{16'h0001, 16'h3800, 16'h0000, 5'b00011, 4'b1000};
      mv[4] = '{16'hC000, 16'h3C00, 16'hC000, 5'b00000, 4'b0100};
      mv[5] = '{16'h3C01, 16'h3C01, 16'h3C02, 5'b00001, 4'b0000};
      mv[6] = '{16'h0200, 16'h4400, 16'h0800, 5'b00000, 4'b0000};

      reset = 1'b1; start = 1'b0; op = 2'd0; fpuIn1 = 16'h3C00; fpuIn2 = 16'h3C00;
      repeat (3) @(negedge clock);
      chk("add_during_reset", fpuOut, 16'h4000);
      op = 2'd2;
      #1;
      chk("rst_out", fpuOut, 16'h0000);
      chk("rst_done", {15'd0, mulDone}, 16'd0);
      chk("rst_flags", {11'd0, statusFlags}, 16'd0);
      chk("rst_cc", {12'd0, condCodes}, 16'h8);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         @(negedge clock);
         op = cv[i].op; fpuIn1 = cv[i].a; fpuIn2 = cv[i].b;
         #1;
         chk($sformatf("comb%0d_out", i), fpuOut, cv[i].res);
         chk($sformatf("comb%0d_flags", i), {11'd0, statusFlags}, {11'd0, cv[i].flg});
         chk($sformatf("comb%0d_cc", i), {12'd0, condCodes}, {12'd0, cv[i].cc});
`ifdef FPU16_COMPARE_EN
         exp_cmp = cv[i].cmp;
`else
         exp_cmp = 3'b000;
`endif
         chk($sformatf("comb%0d_comps", i), {13'd0, comps}, {13'd0, exp_cmp});
      end

      for (int i = 0; i < 7; i++) begin
         run_mul(mv[i].a, mv[i].b, cyc, early);
         chk($sformatf("mul%0d_latency", i), 16'(cyc), 16'd12);
         chk($sformatf("mul%0d_busy", i), {15'd0, early}, 16'd0);
         chk($sformatf("mul%0d_out", i), fpuOut, mv[i].res);
         chk($sformatf("mul%0d_flags", i), {11'd0, statusFlags}, {11'd0, mv[i].flg});
         chk($sformatf("mul%0d_cc", i), {12'd0, condCodes}, {12'd0, mv[i].cc});
      end

      @(negedge clock);
      op = 2'd0; fpuIn1 = 16'h3C00; fpuIn2 = 16'h3C00;
      #1;
      chk("add_after_mul", fpuOut, 16'h4000);
      op = 2'd2;
      #1;
      chk("mul_held", fpuOut, 16'h0800);

      @(negedge clock);
      fpuIn1 = 16'h4000; fpuIn2 = 16'h4200; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clock);
         if (mulDone) seen_done = 1'b1;
      end
      chk("abort_no_done", {15'd0, seen_done}, 16'd0);
      chk("abort_out", fpuOut, 16'h0000);
      chk("abort_flags", {11'd0, statusFlags}, 16'd0);
      chk("abort_cc", {12'd0, condCodes}, 16'h8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fpu16.md
FPU16 -- requirements
Module: fpu16

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse launching a multiply; ignored unless op==MUL.
REQ-004 op  input  2  operation select: 0 ADD, 1 SUB, 2 MUL, 3 reserved (outputs 0000, flags 0).
REQ-005 fpuIn1, fpuIn2  input  16 each  IEEE-754 binary16 operands {sign, exp[4:0], frac[9:0]}.
REQ-006 fpuOut  output  16  binary16 result.
REQ-007 mulDone  output  1  multiply result valid.
REQ-008 condCodes  output  4  {Z, N, I, U}: result ±0, result sign set and not NaN, result ±inf, result NaN.
REQ-009 statusFlags  output  5  {NV, DZ, OF, UF, NX}: invalid, divide-by-zero (always 0), overflow, underflow, inexact.
REQ-010 comps  output  3  {LT, EQ, GT} of fpuIn1 vs fpuIn2.

Function
REQ-011 ADD/SUB SHALL be purely combinational: fpuOut, condCodes, statusFlags track fpuIn1, fpuIn2, op in the same cycle.
REQ-012 SUB SHALL equal ADD with fpuIn2 sign inverted.
REQ-013 All rounding SHALL be round-to-nearest-even, bit-exact with numpy float16 arithmetic.
REQ-014 Subnormal inputs and outputs SHALL be fully supported (no flush-to-zero).
REQ-015 Exact zero sum of opposite-sign operands SHALL yield +0 (0000); (-0)+(-0) yields 8000.
REQ-016 Any NaN result SHALL be canonical 7E00; NaN input propagates as 7E00 (NV=1 only for signalling NaN inputs).
REQ-017 NV SHALL be set for inf-inf (effective subtraction), 0*inf, and sNaN input.
REQ-018 OF SHALL be set when rounded magnitude exceeds 7BFF; result ±inf (7C00/FC00), NX=1.
REQ-019 UF SHALL be set when the result is tiny (below 0400 before rounding) and inexact.
REQ-020 NX SHALL be set whenever the rounded result differs from the exact result.
REQ-021 MUL SHALL be an iterative sequential unit with states IDLE, BUSY, DONE.
REQ-022 IDLE->BUSY when start==1 and op==MUL at a rising edge; operands captured at that edge.
REQ-023 BUSY performs 11-bit shift-and-add mantissa multiply, one partial product per cycle, then one normalize/round cycle; BUSY->DONE exactly 12 cycles after capture.
REQ-024 DONE: mulDone=1, product and flags held in registers until reset or a new start (start in DONE re-enters BUSY, mulDone drops next cycle).
REQ-025 While op==MUL, fpuOut/statusFlags SHALL show the product registers (0000/0 until first completion).
REQ-026 Special-case MUL operands (NaN, inf, zero) SHALL still complete via the same 12-cycle timing.
REQ-027 condCodes SHALL always describe the currently driven fpuOut.

Reset
REQ-028 Reset SHALL force state IDLE, mulDone=0, product register 0000, product flags 0.
REQ-029 Reset mid-multiply SHALL abort the operation; no result is produced.
REQ-030 Reset SHALL NOT affect combinational ADD/SUB outputs.

Configuration
REQ-031 With macro FPU16_COMPARE_EN defined, comps SHALL be combinational: exactly one of LT/EQ/GT set for ordered operands, all 0 if either is NaN, +0 EQ -0.
REQ-032 Without FPU16_COMPARE_EN, comps SHALL be tied to 000 and no comparator logic synthesized.

Verification
REQ-033 ADD 3C00 + 3C00 -> fpuOut 4000, flags 00000, condCodes 0000.
REQ-034 SUB 3C00 - 3C00 -> 0000, Z=1; ADD 3C00 + 0001 -> 3C00, NX=1.
REQ-035 MUL 4000 * 4200 with one-cycle start -> mulDone rises 12 cycles later, fpuOut 4600, flags 00000.
REQ-036 MUL 7BFF * 4000 -> 7C00, OF=1, NX=1, I=1; MUL 0000 * 7C00 -> 7E00, NV=1, U=1.
REQ-037 ADD 7C00 + FC00 -> 7E00, NV=1; ADD 0001 + 0001 -> 0002, UF=0.
REQ-038 Reset asserted 5 cycles into a MUL -> mulDone stays 0, fpuOut 0000 with op==MUL.
